// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage RISC-V pipeline hazard controller.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

endpackage

// File: rtl/hazard_ctrl_mc_if.sv
// Pipeline <-> hazard-controller signal bundle; master is the pipeline, slave is the controller.
interface hazard_ctrl_mc_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              PCSrcE;
  logic              RegWriteE;
  logic              RegWriteM;
  logic              RegWriteW;
  logic [1:0]        ResultSrcE;
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              mem_req_m;
  logic              mem_ready;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  logic              FlushW;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output PCSrcE, RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, mem_req_m, mem_ready,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  PCSrcE, RegWriteE, RegWriteM, RegWriteW, ResultSrcE,
           Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, mem_req_m, mem_ready,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
           ForwardAE, ForwardBE, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // next count, held once saturated
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard/forwarding controller: data-memory wait FSM with timeout, RAW/load-use
// stalls, branch redirect flushes, E-stage forwarding and stall/flush counters.
module hazard_ctrl_mc
  import riscv_pipe_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter bit FWD_EN  = 1'b1,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  hazard_ctrl_mc_if.slave hz
);
  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);
  localparam logic [REG_AW-1:0] RZ = {REG_AW{1'b0}};

  mem_state_t        state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic     mem_stall_s, raw_stall_s, e_match_s, m_match_s;
  logic     stall_f_s, stall_d_s, stall_e_s, stall_m_s;
  logic     flush_d_s, flush_e_s, flush_w_s;
  fwd_sel_t fwd_a_s, fwd_b_s;

  // memory FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      wait_cnt_q <= {WCNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // memory FSM next state; a ready in the request cycle never enters WAIT
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (hz.mem_req_m && !hz.mem_ready) begin
          state_d    = WAIT;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else begin
          state_d = RUN;
        end
      end
      WAIT: begin
        if (hz.mem_ready) begin
          state_d    = RUN;
          wait_cnt_d = {WCNT_W{1'b0}};
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // hazard detection and pipeline control outputs
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_d_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    fwd_a_s   = FWD_RF;
    fwd_b_s   = FWD_RF;

    mem_stall_s = ((state_q == RUN) && hz.mem_req_m && !hz.mem_ready) ||
                  ((state_q == WAIT) && !hz.mem_ready) ||
                  (state_q == ERR);
    e_match_s = (hz.RdE != RZ) && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    m_match_s = (hz.RdM != RZ) && ((hz.RdM == hz.Rs1D) || (hz.RdM == hz.Rs2D));
    // without forwarding only W is safe (write-through reg file); E and M must wait
    if (FWD_EN) begin
      raw_stall_s = (hz.ResultSrcE == RESULT_LOAD) && e_match_s;
    end else begin
      raw_stall_s = (hz.RegWriteE && e_match_s) || (hz.RegWriteM && m_match_s);
    end

    if (!rst_n) begin
      stall_f_s = 1'b0;
    end else if (mem_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else if (raw_stall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end

    if (rst_n && FWD_EN) begin
      if (hz.RegWriteM && (hz.RdM != RZ) && (hz.RdM == hz.Rs1E)) begin
        fwd_a_s = FWD_M;
      end else if (hz.RegWriteW && (hz.RdW != RZ) && (hz.RdW == hz.Rs1E)) begin
        fwd_a_s = FWD_W;
      end else begin
        fwd_a_s = FWD_RF;
      end
      if (hz.RegWriteM && (hz.RdM != RZ) && (hz.RdM == hz.Rs2E)) begin
        fwd_b_s = FWD_M;
      end else if (hz.RegWriteW && (hz.RdW != RZ) && (hz.RdW == hz.Rs2E)) begin
        fwd_b_s = FWD_W;
      end else begin
        fwd_b_s = FWD_RF;
      end
    end else begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
    end
  end

  assign hz.StallF    = stall_f_s;
  assign hz.StallD    = stall_d_s;
  assign hz.StallE    = stall_e_s;
  assign hz.StallM    = stall_m_s;
  assign hz.FlushD    = flush_d_s;
  assign hz.FlushE    = flush_e_s;
  assign hz.FlushW    = flush_w_s;
  assign hz.ForwardAE = fwd_a_s;
  assign hz.ForwardBE = fwd_b_s;
  assign hz.mem_err   = (state_q == ERR);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_f_s),
    .cnt_o (hz.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_d_s),
    .cnt_o (hz.flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench: a forwarding instance (CNT_W=32) and a stall-only instance (CNT_W=4).
module tb_hazard_ctrl_mc;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) hz1 ();
  hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4))  hz0 ();

  hazard_ctrl_mc #(.REG_AW(5), .FWD_EN(1'b1), .TIMEOUT(16), .CNT_W(32)) u_fwd (
    .clk(clk), .rst_n(rst_n), .hz(hz1)
  );
  hazard_ctrl_mc #(.REG_AW(5), .FWD_EN(1'b0), .TIMEOUT(16), .CNT_W(4)) u_stl (
    .clk(clk), .rst_n(rst_n), .hz(hz0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    hz1.PCSrcE = 1'b0; hz1.RegWriteE = 1'b0; hz1.RegWriteM = 1'b0; hz1.RegWriteW = 1'b0;
    hz1.ResultSrcE = 2'b00; hz1.Rs1D = 5'd0; hz1.Rs2D = 5'd0; hz1.Rs1E = 5'd0; hz1.Rs2E = 5'd0;
    hz1.RdE = 5'd0; hz1.RdM = 5'd0; hz1.RdW = 5'd0; hz1.mem_req_m = 1'b0; hz1.mem_ready = 1'b0;
    hz0.PCSrcE = 1'b0; hz0.RegWriteE = 1'b0; hz0.RegWriteM = 1'b0; hz0.RegWriteW = 1'b0;
    hz0.ResultSrcE = 2'b00; hz0.Rs1D = 5'd0; hz0.Rs2D = 5'd0; hz0.Rs1E = 5'd0; hz0.Rs2E = 5'd0;
    hz0.RdE = 5'd0; hz0.RdM = 5'd0; hz0.RdW = 5'd0; hz0.mem_req_m = 1'b0; hz0.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    hz1.ResultSrcE = 2'b01; hz1.RdE = 5'd6; hz1.Rs1D = 5'd6;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM, hz1.FlushD, hz1.FlushE, hz1.FlushW} !== 7'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0000000",
        {hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM, hz1.FlushD, hz1.FlushE, hz1.FlushW});
    end
    checks++;
    if (hz1.mem_err !== 1'b0 || hz1.stall_cnt !== 32'd0 || hz1.flush_cnt !== 32'd0) begin
      failures++; $display("FAIL reset_state err=%b stall=%0d flush=%0d exp=0/0/0",
        hz1.mem_err, hz1.stall_cnt, hz1.flush_cnt);
    end
    idle();
    rst_n = 1'b1;
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    hz1.RegWriteM = 1'b1; hz1.RdM = 5'd5; hz1.Rs1E = 5'd5; hz1.Rs2E = 5'd7;
    #1 checks++;
    if (hz1.ForwardAE !== 2'b10 || hz1.ForwardBE !== 2'b00) begin
      failures++; $display("FAIL fwd_m got=%b/%b exp=10/00", hz1.ForwardAE, hz1.ForwardBE);
    end
    hz1.RegWriteW = 1'b1; hz1.RdW = 5'd7;
    #1 checks++;
    if (hz1.ForwardAE !== 2'b10 || hz1.ForwardBE !== 2'b01) begin
      failures++; $display("FAIL fwd_mw got=%b/%b exp=10/01", hz1.ForwardAE, hz1.ForwardBE);
    end
    hz1.RdW = 5'd5; hz1.Rs2E = 5'd5;
    #1 checks++;
    if (hz1.ForwardAE !== 2'b10 || hz1.ForwardBE !== 2'b10) begin
      failures++; $display("FAIL fwd_prio got=%b/%b exp=10/10", hz1.ForwardAE, hz1.ForwardBE);
    end
    hz1.RegWriteM = 1'b0;
    #1 checks++;
    if (hz1.ForwardAE !== 2'b01) begin
      failures++; $display("FAIL fwd_w got=%b exp=01", hz1.ForwardAE);
    end
    @(negedge clk);
    hz1.RegWriteM = 1'b1; hz1.RdM = 5'd0; hz1.RdW = 5'd0; hz1.Rs1E = 5'd0; hz1.Rs2E = 5'd0;
    #1 checks++;
    if (hz1.ForwardAE !== 2'b00 || hz1.ForwardBE !== 2'b00) begin
      failures++; $display("FAIL fwd_x0 got=%b/%b exp=00/00", hz1.ForwardAE, hz1.ForwardBE);
    end
    idle();
  endtask

  task automatic test_load_use();
    @(negedge clk);
    hz1.ResultSrcE = 2'b01; hz1.RegWriteE = 1'b1; hz1.RdE = 5'd6; hz1.Rs2D = 5'd6;
    #1 checks++;
    if ({hz1.StallF, hz1.StallD, hz1.FlushE, hz1.FlushD, hz1.StallE, hz1.StallM, hz1.FlushW} !== 7'b1110000) begin
      failures++; $display("FAIL load_use got=%b exp=1110000",
        {hz1.StallF, hz1.StallD, hz1.FlushE, hz1.FlushD, hz1.StallE, hz1.StallM, hz1.FlushW});
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (hz1.stall_cnt !== 32'd1 || hz1.flush_cnt !== 32'd0 || hz1.StallF !== 1'b0) begin
      failures++; $display("FAIL load_use_cnt stall=%0d flush=%0d StallF=%b exp=1/0/0",
        hz1.stall_cnt, hz1.flush_cnt, hz1.StallF);
    end
    hz1.ResultSrcE = 2'b01; hz1.RdE = 5'd0; hz1.Rs1D = 5'd0;
    #1 checks++;
    if (hz1.StallF !== 1'b0) begin
      failures++; $display("FAIL load_x0 got=%b exp=0", hz1.StallF);
    end
    idle();
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    hz1.mem_req_m = 1'b1; hz1.mem_ready = 1'b0;
    hz1.ResultSrcE = 2'b01; hz1.RdE = 5'd6; hz1.Rs1D = 5'd6;
    for (int i = 0; i < 3; i++) begin
      #1 checks++;
      if ({hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM, hz1.FlushW, hz1.FlushD, hz1.FlushE} !== 7'b1111100) begin
        failures++; $display("FAIL mem_wait cyc=%0d got=%b exp=1111100", i,
          {hz1.StallF, hz1.StallD, hz1.StallE, hz1.StallM, hz1.FlushW, hz1.FlushD, hz1.FlushE});
      end
      @(negedge clk);
    end
    hz1.mem_ready = 1'b1; hz1.ResultSrcE = 2'b00; hz1.RdE = 5'd0; hz1.Rs1D = 5'd0;
    #1 checks++;
    if ({hz1.StallF, hz1.StallM, hz1.FlushW} !== 3'b000) begin
      failures++; $display("FAIL mem_release got=%b exp=000", {hz1.StallF, hz1.StallM, hz1.FlushW});
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (hz1.stall_cnt !== 32'd4 || hz1.StallF !== 1'b0) begin
      failures++; $display("FAIL mem_wait_cnt stall=%0d StallF=%b exp=4/0", hz1.stall_cnt, hz1.StallF);
    end
  endtask

  task automatic test_timeout();
    @(negedge clk);
    hz1.mem_req_m = 1'b1; hz1.mem_ready = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hz1.mem_err !== 1'b0 || hz1.StallF !== 1'b1) begin
      failures++; $display("FAIL timeout_early err=%b StallF=%b exp=0/1", hz1.mem_err, hz1.StallF);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (hz1.mem_err !== 1'b1 || hz1.stall_cnt !== 32'd21) begin
      failures++; $display("FAIL timeout_err err=%b stall=%0d exp=1/21", hz1.mem_err, hz1.stall_cnt);
    end
    hz1.mem_req_m = 1'b0; hz1.mem_ready = 1'b1; hz1.PCSrcE = 1'b1;
    #1 checks++;
    if ({hz1.StallF, hz1.StallM, hz1.FlushW, hz1.FlushD, hz1.FlushE} !== 5'b11100) begin
      failures++; $display("FAIL err_sticky got=%b exp=11100",
        {hz1.StallF, hz1.StallM, hz1.FlushW, hz1.FlushD, hz1.FlushE});
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (hz1.mem_err !== 1'b1 || hz1.stall_cnt !== 32'd22 || hz1.flush_cnt !== 32'd0) begin
      failures++; $display("FAIL err_hold err=%b stall=%0d flush=%0d exp=1/22/0",
        hz1.mem_err, hz1.stall_cnt, hz1.flush_cnt);
    end
    rst_n = 1'b0;
    #1 checks++;
    if (hz1.mem_err !== 1'b0 || hz1.stall_cnt !== 32'd0 || hz1.StallF !== 1'b0) begin
      failures++; $display("FAIL err_reset err=%b stall=%0d StallF=%b exp=0/0/0",
        hz1.mem_err, hz1.stall_cnt, hz1.StallF);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (hz1.StallF !== 1'b0 || hz1.mem_err !== 1'b0) begin
      failures++; $display("FAIL post_reset StallF=%b err=%b exp=0/0", hz1.StallF, hz1.mem_err);
    end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    hz1.ResultSrcE = 2'b01; hz1.RdE = 5'd6; hz1.Rs2D = 5'd6; hz1.PCSrcE = 1'b1;
    #1 checks++;
    if ({hz1.FlushD, hz1.FlushE, hz1.StallF, hz1.StallD} !== 4'b1100) begin
      failures++; $display("FAIL redirect got=%b exp=1100", {hz1.FlushD, hz1.FlushE, hz1.StallF, hz1.StallD});
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (hz1.flush_cnt !== 32'd1 || hz1.stall_cnt !== 32'd0) begin
      failures++; $display("FAIL redirect_cnt flush=%0d stall=%0d exp=1/0", hz1.flush_cnt, hz1.stall_cnt);
    end
    hz1.PCSrcE = 1'b1; hz1.mem_req_m = 1'b1; hz1.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1 checks++;
      if ({hz1.FlushD, hz1.FlushE, hz1.StallF} !== 3'b001) begin
        failures++; $display("FAIL redirect_held cyc=%0d got=%b exp=001", i, {hz1.FlushD, hz1.FlushE, hz1.StallF});
      end
      @(negedge clk);
    end
    hz1.mem_ready = 1'b1;
    #1 checks++;
    if ({hz1.FlushD, hz1.FlushE, hz1.StallF} !== 3'b110) begin
      failures++; $display("FAIL redirect_release got=%b exp=110", {hz1.FlushD, hz1.FlushE, hz1.StallF});
    end
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    checks++;
    if (hz1.flush_cnt !== 32'd2 || hz1.stall_cnt !== 32'd2) begin
      failures++; $display("FAIL redirect_cnt2 flush=%0d stall=%0d exp=2/2", hz1.flush_cnt, hz1.stall_cnt);
    end
  endtask

  task automatic test_no_fwd();
    @(negedge clk);
    hz0.RegWriteM = 1'b1; hz0.RdM = 5'd3; hz0.Rs1D = 5'd3; hz0.Rs1E = 5'd3;
    #1 checks++;
    if ({hz0.StallF, hz0.StallD, hz0.FlushE} !== 3'b111 || hz0.ForwardAE !== 2'b00) begin
      failures++; $display("FAIL nofwd_m got=%b fwd=%b exp=111/00", {hz0.StallF, hz0.StallD, hz0.FlushE}, hz0.ForwardAE);
    end
    hz0.RegWriteM = 1'b0; hz0.RegWriteW = 1'b1; hz0.RdW = 5'd4; hz0.Rs1D = 5'd4;
    #1 checks++;
    if (hz0.StallD !== 1'b0) begin
      failures++; $display("FAIL nofwd_w got=%b exp=0", hz0.StallD);
    end
    hz0.RegWriteE = 1'b0; hz0.RdE = 5'd9; hz0.Rs2D = 5'd9;
    #1 checks++;
    if (hz0.StallD !== 1'b0) begin
      failures++; $display("FAIL nofwd_e_nowr got=%b exp=0", hz0.StallD);
    end
    @(negedge clk);
    hz0.RegWriteE = 1'b1;
    #1 checks++;
    if (hz0.StallD !== 1'b1) begin
      failures++; $display("FAIL nofwd_e got=%b exp=1", hz0.StallD);
    end
    @(negedge clk);
    checks++;
    if (hz0.stall_cnt !== 4'd1) begin
      failures++; $display("FAIL nofwd_cnt got=%0d exp=1", hz0.stall_cnt);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hz0.stall_cnt !== 4'hF || hz0.flush_cnt !== 4'd0) begin
      failures++; $display("FAIL stall_sat stall=%0d flush=%0d exp=15/0", hz0.stall_cnt, hz0.flush_cnt);
    end
    idle();
    hz0.PCSrcE = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (hz0.flush_cnt !== 4'hF || hz0.stall_cnt !== 4'hF) begin
      failures++; $display("FAIL flush_sat flush=%0d stall=%0d exp=15/15", hz0.flush_cnt, hz0.stall_cnt);
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_redirect();
    test_no_fwd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
